// File: rtl/fibo_seq_engine_if.sv
// fibo_seq_engine_if: start/seed/result bundle for fibo_seq_engine.
// master = requester (drives start, index, seeds); slave = engine.
interface fibo_seq_engine_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
);
    logic             begin_fibo;
    logic [IDX_W-1:0] input_s;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [WIDTH-1:0] fibo_out;
    logic             done;
    logic             busy;
    logic             overflow;

    modport master (
        output begin_fibo, input_s, seed0, seed1,
        input  fibo_out, done, busy, overflow
    );

    modport slave (
        input  begin_fibo, input_s, seed0, seed1,
        output fibo_out, done, busy, overflow
    );
endinterface

// File: rtl/fibo_seq_engine.sv
// fibo_seq_engine: computes F(n) of F(k) = F(k-1) + F(k-2) with programmable
// seeds F(0)/F(1). One term is advanced per clock in RUN; the overflow flag
// travels with each term so only terms F(2)..F(n) can raise it.
// Optional macro FIBO_SAT_EN: terms saturate at all-ones instead of wrapping.
module fibo_seq_engine #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    fibo_seq_engine_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ovf_a;
    logic             r_ovf_b;
    logic [WIDTH-1:0] r_fibo_out;
    logic             r_done;
    logic             r_busy;
    logic             r_overflow;

    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_next;

    // Next-term selection: wrap modulo 2^WIDTH, or clamp to all-ones.
    function automatic logic [WIDTH-1:0] f_next_term(input logic [WIDTH:0] sum);
`ifdef FIBO_SAT_EN
        return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        return sum[WIDTH-1:0];
`endif
    endfunction

    // Widened adder so the carry out is an exact overflow indication.
    always_comb begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_carry = w_sum[WIDTH];
        w_next  = f_next_term(w_sum);
    end

    // Control FSM with registered outputs; a holds F(cnt) throughout RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_ovf_a    <= 1'b0;
            r_ovf_b    <= 1'b0;
            r_fibo_out <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.begin_fibo) begin
                        r_n     <= bus.input_s;
                        r_a     <= bus.seed0;
                        r_b     <= bus.seed1;
                        r_cnt   <= '0;
                        r_ovf_a <= 1'b0;
                        r_ovf_b <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt == r_n) begin
                        r_fibo_out <= r_a;
                        r_overflow <= r_ovf_a;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_a     <= r_b;
                        r_ovf_a <= r_ovf_b;
                        r_b     <= w_next;
                        // Once a term has overflowed, every later term inherits it.
                        r_ovf_b <= w_carry | r_ovf_a | r_ovf_b;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fibo_out = r_fibo_out;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Scoreboard bench for fibo_seq_engine (WIDTH=16, IDX_W=5).
module tb_fibo_seq_engine;

    localparam int WIDTH = 16;
    localparam int IDX_W = 5;

    logic clk;
    logic rst_n;

    fibo_seq_engine_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus_if ();

    fibo_seq_engine #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    typedef struct {
        logic [WIDTH-1:0] val;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: pop an expectation at every done pulse.
    always @(negedge clk) begin
        if (rst_n && bus_if.done === 1'b1) begin
            exp_t e;
            done_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got fibo_out=%0d overflow=%0b, required no done", bus_if.fibo_out, bus_if.overflow);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.fibo_out !== e.val || bus_if.overflow !== e.ovf) begin
                    bad++;
                    $display("FAIL result: got fibo_out=%0d overflow=%0b, required fibo_out=%0d overflow=%0b",
                             bus_if.fibo_out, bus_if.overflow, e.val, e.ovf);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Drive a start request for one cycle (the next rising edge is E0).
    task automatic issue(input int n, input int s0, input int s1);
        bus_if.begin_fibo = 1'b1;
        bus_if.input_s    = IDX_W'(n);
        bus_if.seed0      = WIDTH'(s0);
        bus_if.seed1      = WIDTH'(s1);
        @(posedge clk); #1;
        bus_if.begin_fibo = 1'b0;
        bus_if.input_s    = '1;
        bus_if.seed0      = 16'hAAAA;
        bus_if.seed1      = 16'h5555;
    endtask

    // Full run: push expectation, start, check done edge and busy length.
    task automatic run(input string name, input int n, input int s0, input int s1,
                       input int exp_val, input bit exp_ovf);
        exp_t e;
        int k;
        int busy_cnt;
        int done_edge;
        e.val = WIDTH'(exp_val);
        e.ovf = exp_ovf;
        exp_q.push_back(e);
        issue(n, s0, s1);
        k = 0; busy_cnt = 0; done_edge = -1;
        while (k < 100) begin
            if (bus_if.busy === 1'b1) busy_cnt++;
            else break;
            @(posedge clk); #1;
            k++;
            if (bus_if.done === 1'b1 && done_edge < 0) done_edge = k;
        end
        check({name, "_done_edge"}, done_edge, n + 1);
        check({name, "_busy_cycles"}, busy_cnt, n + 2);
    endtask

    initial begin
        int d0;
        int k;
        rst_n             = 1'b0;
        bus_if.begin_fibo = 1'b0;
        bus_if.input_s    = '0;
        bus_if.seed0      = '0;
        bus_if.seed1      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fibo_out", int'(bus_if.fibo_out), 0);
        check("reset_done",     int'(bus_if.done),     0);
        check("reset_busy",     int'(bus_if.busy),     0);
        check("reset_overflow", int'(bus_if.overflow), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("fib_n0",  0, 0, 1, 0, 1'b0);
        run("fib_n1",  1, 0, 1, 1, 1'b0);
        run("fib_n10", 10, 0, 1, 55, 1'b0);
        run("fib_n24", 24, 0, 1, 46368, 1'b0);
`ifdef FIBO_SAT_EN
        run("fib_n25", 25, 0, 1, 65535, 1'b1);
`else
        run("fib_n25", 25, 0, 1, 9489, 1'b1);
`endif
        run("lucas_n10", 10, 2, 1, 123, 1'b0);
        run("seed50_n3", 3, 5, 0, 5, 1'b0);

        // Mid-run start request must be ignored, single done produced.
        d0 = done_seen;
        run("ignore_n20", 20, 0, 1, 6765, 1'b0);
        // (run samples the edges itself; inject the stray request in a second pass)
        d0 = done_seen;
        begin
            exp_t e;
            e.val = 16'd6765; e.ovf = 1'b0;
            exp_q.push_back(e);
        end
        issue(20, 0, 1);
        repeat (4) @(posedge clk);
        #1;
        issue(3, 0, 1);
        k = 0;
        while (bus_if.done !== 1'b1 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("ignore_done_reached", int'(bus_if.done), 1);
        @(posedge clk); #1;
        // Now in the cycle after DONE: this request must be accepted.
        run("after_done_n3", 3, 0, 1, 2, 1'b0);
        check("ignore_single_done", done_seen - d0, 2);

        // Asynchronous reset mid-run.
        d0 = done_seen;
        issue(20, 0, 1);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_fibo_out", int'(bus_if.fibo_out), 0);
        check("abort_done",     int'(bus_if.done),     0);
        check("abort_busy",     int'(bus_if.busy),     0);
        check("abort_overflow", int'(bus_if.overflow), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", done_seen - d0, 0);
        run("post_reset_n5", 5, 0, 1, 5, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
